// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the pause fader
package audio_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    MUTED    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [15:0] AUDIO_MID = 16'h8000;
  localparam logic [8:0]  GAIN_FULL = 9'd256;

endpackage

// File: rtl/audio_gain_mul.sv
// rtl/audio_gain_mul.sv - two-stage midpoint-relative gain pipeline
module audio_gain_mul
  import audio_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] audio_in,
  input  logic [8:0]  gain,
  output logic [15:0] audio_out
);

  logic [15:0]        samp_q, samp_d;
  logic [15:0]        out_q, out_d;
  logic signed [15:0] s;
  logic signed [9:0]  g;
  logic signed [25:0] p;
  logic               unused_p;

  always_comb begin
    samp_d = audio_in;
    s      = $signed(samp_q ^ AUDIO_MID);
    g      = $signed({1'b0, gain});
    p      = $signed({{10{s[15]}}, s}) * $signed({16'd0, g});
    // Dropping the low 8 bits of a two's complement value is a floor shift.
    out_d  = p[23:8] ^ AUDIO_MID;
  end

  // |s| * 256 fits in 24 bits, so the top product bits never carry data.
  assign unused_p = ^{p[25:24], p[7:0]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      samp_q <= AUDIO_MID;
      out_q  <= AUDIO_MID;
    end else begin
      samp_q <= samp_d;
      out_q  <= out_d;
    end
  end

  assign audio_out = out_q;

endmodule

// File: rtl/audio_pause_fader.sv
// rtl/audio_pause_fader.sv - click-free pause fade between core audio and output
module audio_pause_fader
  import audio_pkg::*;
#(
  parameter int STEP_DIV = 1600,
  parameter int GAIN_MAX = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        pause,
  input  logic        fade_en,
  input  logic [15:0] audio_in,
  output logic [15:0] audio_out,
  output logic        muted,
  output logic [8:0]  gain
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  fade_state_t       state_q, state_d;
  logic [8:0]        gain_q, gain_d, gain_step;
  logic [CNT_W-1:0]  tick_q, tick_d;
  logic              muted_q, muted_d;
  logic              step;
  logic              unused_param;

  assign unused_param = (GAIN_MAX != 256);

  // Free-running divider; pause edges never restart it.
  always_comb begin
    step   = (tick_q == CNT_W'(STEP_DIV - 1));
    tick_d = step ? '0 : tick_q + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    gain_d    = gain_q;
    gain_step = gain_q;
    if (!fade_en) begin
      if (pause) begin
        state_d = MUTED;
        gain_d  = 9'd0;
      end else begin
        state_d = PLAY;
        gain_d  = GAIN_FULL;
      end
    end else begin
      case (state_q)
        PLAY: begin
          if (pause) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          // A coincident step lands in the old direction before reversing.
          if (step && gain_q != 9'd0) gain_step = gain_q - 9'd1;
          gain_d = gain_step;
          if (!pause)                  state_d = FADE_IN;
          else if (gain_step == 9'd0)  state_d = MUTED;
        end
        MUTED: begin
          if (!pause) state_d = FADE_IN;
        end
        FADE_IN: begin
          if (step && gain_q < GAIN_FULL) gain_step = gain_q + 9'd1;
          gain_d = gain_step;
          if (pause)                        state_d = FADE_OUT;
          else if (gain_step == GAIN_FULL)  state_d = PLAY;
        end
        default: begin
          state_d = PLAY;
          gain_d  = GAIN_FULL;
        end
      endcase
    end
    muted_d = (state_d == MUTED);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= PLAY;
      gain_q  <= GAIN_FULL;
      tick_q  <= '0;
      muted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      tick_q  <= tick_d;
      muted_q <= muted_d;
    end
  end

  audio_gain_mul u_gain_mul (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .audio_in  (audio_in),
    .gain      (gain_q),
    .audio_out (audio_out)
  );

  assign muted = muted_q;
  assign gain  = gain_q;

endmodule

// File: tb/tb_audio_pause_fader.sv
// tb/tb_audio_pause_fader.sv - directed self-checking bench for audio_pause_fader
module tb_audio_pause_fader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        pause;
  logic        fade_en;
  logic [15:0] audio_in;
  logic [15:0] audio_out;
  logic        muted;
  logic [8:0]  gain;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc;

  always #5 clk_sys = ~clk_sys;

  audio_pause_fader #(.STEP_DIV(4), .GAIN_MAX(256)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pause     (pause),
    .fade_en   (fade_en),
    .audio_in  (audio_in),
    .audio_out (audio_out),
    .muted     (muted),
    .gain      (gain)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gain(input logic [8:0] target, input int budget, output int cycles);
    cycles = 0;
    while (gain !== target && cycles < budget) begin
      @(negedge clk_sys);
      cycles++;
    end
  endtask

  task automatic cycles_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  initial begin
    reset    = 1'b1;
    pause    = 1'b0;
    fade_en  = 1'b1;
    audio_in = 16'h8000;
    cycles_n(3);
    check_vec("rst_gain", 32'(gain), 32'd256);
    check_vec("rst_muted", 32'(muted), 32'd0);
    check_vec("rst_out", 32'(audio_out), 32'h8000);

    // passthrough
    reset    = 1'b0;
    audio_in = 16'hC000;
    cycles_n(2);
    check_vec("pass_out", 32'(audio_out), 32'hC000);
    check_vec("pass_gain", 32'(gain), 32'd256);
    check_vec("pass_muted", 32'(muted), 32'd0);

    // full fade-out with constant full-scale input
    audio_in = 16'hFFFF;
    cycles_n(2);
    check_vec("full_pos_out", 32'(audio_out), 32'hFFFF);
    pause = 1'b1;
    wait_gain(9'd255, 40, cyc);
    check_vec("fo_first_step", 32'(gain), 32'd255);
    wait_gain(9'd254, 40, cyc);
    check_vec("fo_step_spacing", 32'(cyc), 32'd4);
    wait_gain(9'd128, 1100, cyc);
    check_vec("fo_reach_128", 32'(gain), 32'd128);
    cycles_n(1);
    check_vec("fo_out_g128", 32'(audio_out), 32'hBFFF);
    wait_gain(9'd0, 1100, cyc);
    check_vec("fo_reach_0", 32'(gain), 32'd0);
    check_vec("fo_muted", 32'(muted), 32'd1);
    cycles_n(2);
    check_vec("fo_out_silent", 32'(audio_out), 32'h8000);
    check_vec("fo_hold_0", 32'(gain), 32'd0);

    // fade back in from mute
    pause = 1'b0;
    cycles_n(1);
    check_vec("fi_unmuted", 32'(muted), 32'd0);
    check_vec("fi_gain_start", 32'(gain), 32'd0);
    wait_gain(9'd256, 1100, cyc);
    check_vec("fi_reach_256", 32'(gain), 32'd256);
    cycles_n(2);
    check_vec("fi_out_full", 32'(audio_out), 32'hFFFF);

    // reversal mid-ramp at gain 200
    pause = 1'b1;
    wait_gain(9'd200, 300, cyc);
    check_vec("rev_reach_200", 32'(gain), 32'd200);
    pause = 1'b0;
    cycles_n(1);
    check_vec("rev_no_jump", 32'(gain), 32'd200);
    check_vec("rev_muted", 32'(muted), 32'd0);
    wait_gain(9'd201, 8, cyc);
    check_vec("rev_up_201", 32'(gain), 32'd201);
    wait_gain(9'd256, 400, cyc);
    check_vec("rev_reach_256", 32'(gain), 32'd256);
    cycles_n(12);
    check_vec("rev_stays_play", 32'(gain), 32'd256);

    // negative rounding at gain 128
    pause = 1'b1;
    wait_gain(9'd128, 1100, cyc);
    check_vec("neg_reach_128", 32'(gain), 32'd128);
    audio_in = 16'h0001;
    cycles_n(2);
    check_vec("neg_gain_held", 32'(gain), 32'd128);
    check_vec("neg_out_floor", 32'(audio_out), 32'h4000);

    // reset mid-fade at gain 77
    wait_gain(9'd77, 600, cyc);
    check_vec("rstf_reach_77", 32'(gain), 32'd77);
    reset = 1'b1;
    cycles_n(1);
    check_vec("rstf_gain", 32'(gain), 32'd256);
    check_vec("rstf_muted", 32'(muted), 32'd0);
    check_vec("rstf_out", 32'(audio_out), 32'h8000);
    reset    = 1'b0;
    pause    = 1'b0;
    audio_in = 16'h1234;
    cycles_n(1);
    check_vec("rstf_out_pipe", 32'(audio_out), 32'h8000);
    cycles_n(1);
    check_vec("rstf_pass", 32'(audio_out), 32'h1234);
    check_vec("rstf_gain_play", 32'(gain), 32'd256);

    // hard mute / unmute
    fade_en = 1'b0;
    pause   = 1'b1;
    cycles_n(1);
    check_vec("hard_gain0", 32'(gain), 32'd0);
    check_vec("hard_muted", 32'(muted), 32'd1);
    cycles_n(2);
    check_vec("hard_out_silent", 32'(audio_out), 32'h8000);
    pause = 1'b0;
    cycles_n(1);
    check_vec("hard_gain_full", 32'(gain), 32'd256);
    check_vec("hard_unmuted", 32'(muted), 32'd0);
    cycles_n(2);
    check_vec("hard_out_pass", 32'(audio_out), 32'h1234);

    // fade_en dropped mid-ramp snaps to the endpoint chosen by pause
    fade_en = 1'b1;
    pause   = 1'b1;
    wait_gain(9'd250, 64, cyc);
    check_vec("snap_reach_250", 32'(gain), 32'd250);
    fade_en = 1'b0;
    cycles_n(1);
    check_vec("snap_down", 32'(gain), 32'd0);
    check_vec("snap_down_muted", 32'(muted), 32'd1);
    fade_en = 1'b1;
    pause   = 1'b0;
    wait_gain(9'd5, 64, cyc);
    check_vec("snap_reach_5", 32'(gain), 32'd5);
    fade_en = 1'b0;
    cycles_n(1);
    check_vec("snap_up", 32'(gain), 32'd256);
    check_vec("snap_up_muted", 32'(muted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
